// File: rtl/text_writer_if.sv
// text_writer_if: character stream handshake and text RAM write port.
// master = character producer / RAM observer, slave = text_writer.
interface text_writer_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  s_valid;
    logic [7:0]            s_char;
    logic                  s_last;
    logic                  s_ready;
    logic                  we;
    logic [ADDR_WIDTH-3:0] wa;
    logic [31:0]           wdata;

    modport master (
        output s_valid, s_char, s_last,
        input  s_ready, we, wa, wdata
    );

    modport slave (
        input  s_valid, s_char, s_last,
        output s_ready, we, wa, wdata
    );
endinterface

// File: rtl/text_writer.sv
// text_writer: packs a byte character stream into 32-bit text RAM words.
// Optional TEXT_WRITER_VBLANK_EN defers word writes until vblank=1.
module text_writer #(
    parameter int         TEXT_WIDTH  = 16,
    parameter int         TEXT_HEIGHT = 16,
    parameter logic [7:0] FILL_CHAR   = 8'h00,
    localparam int ADDR_WIDTH = $clog2(TEXT_WIDTH) + $clog2(TEXT_HEIGHT),
    localparam int WORDS      = TEXT_WIDTH * TEXT_HEIGHT / 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    text_writer_if.slave          bus,
    input  logic                  set_cursor,
    input  logic [ADDR_WIDTH-1:0] cursor_in,
    input  logic                  clear,
`ifdef TEXT_WRITER_VBLANK_EN
    input  logic                  vblank,
`endif
    output logic                  busy
);
    localparam int WA_W = ADDR_WIDTH - 2;
    localparam logic [31:0] FILL_WORD = {4{FILL_CHAR}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
    logic [31:0]           buf_q, buf_d;
    logic                  pend_q, pend_d;
    logic                  we_q, we_d;
    logic [WA_W-1:0]       wa_q, wa_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           buf_new;
    logic                  go;

`ifdef TEXT_WRITER_VBLANK_EN
    assign go = vblank;
`else
    assign go = 1'b1;
`endif

    assign bus.s_ready = (state_q == IDLE) && !clear && !set_cursor;
    assign bus.we      = we_q && go;
    assign bus.wa      = wa_q;
    assign bus.wdata   = wdata_q;
    assign busy        = (state_q != IDLE);

    // Next-state logic: command priority, byte packing and clear sweep.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        buf_d    = buf_q;
        pend_d   = pend_q;
        we_d     = we_q;
        wa_d     = wa_q;
        wdata_d  = wdata_q;
        buf_new  = buf_q;
        buf_new[{cursor_q[1:0], 3'b000} +: 8] = bus.s_char;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    buf_d   = FILL_WORD;
                    pend_d  = 1'b0;
                    we_d    = 1'b1;
                    wa_d    = '0;
                    wdata_d = FILL_WORD;
                end else if (set_cursor) begin
                    cursor_d = cursor_in;
                    if (pend_q) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        wa_d    = cursor_q[ADDR_WIDTH-1:2];
                        wdata_d = buf_q;
                        buf_d   = FILL_WORD;
                        pend_d  = 1'b0;
                    end
                end else if (bus.s_valid) begin
                    cursor_d = cursor_q + ADDR_WIDTH'(1);
                    if (cursor_q[1:0] == 2'd3 || bus.s_last) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        wa_d    = cursor_q[ADDR_WIDTH-1:2];
                        wdata_d = buf_new;
                        buf_d   = FILL_WORD;
                        pend_d  = 1'b0;
                    end else begin
                        buf_d  = buf_new;
                        pend_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (go) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                end
            end
            CLEAR: begin
                if (go) begin
                    if (wa_q == WA_W'(WORDS - 1)) begin
                        state_d  = IDLE;
                        we_d     = 1'b0;
                        cursor_d = '0;
                    end else begin
                        wa_d = wa_q + WA_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and registered write-port outputs; reset aborts any sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cursor_q <= '0;
            buf_q    <= FILL_WORD;
            pend_q   <= 1'b0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            buf_q    <= buf_d;
            pend_q   <= pend_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: scoreboard bench for text_writer (16x16 text, fill 0).
// Expected RAM writes come from a character-address model of the stream.
module tb_text_writer;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          set_cursor = 1'b0;
    logic [AW-1:0] cursor_in = '0;
    logic          clear = 1'b0;
    logic          busy;

    int checks = 0;
    int failures = 0;

    text_writer_if #(.ADDR_WIDTH(AW)) ifc ();

    text_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (ifc),
        .set_cursor (set_cursor),
        .cursor_in  (cursor_in),
        .clear      (clear),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-3:0] wa;
        logic [31:0]   wd;
    } wr_t;

    wr_t        exp_q[$];
    int         m_cursor;
    logic [7:0] p_chr[$];
    int         p_adr[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: emit the word holding all pending characters, rest filled.
    function automatic void flush();
        wr_t w;
        w.wd = 32'h0;
        w.wa = AW'(p_adr[0] / 4);
        foreach (p_chr[i]) w.wd[8*(p_adr[i]%4) +: 8] = p_chr[i];
        exp_q.push_back(w);
        p_chr.delete();
        p_adr.delete();
    endfunction

    function automatic void model_char(logic [7:0] c, bit last);
        int a = m_cursor;
        p_chr.push_back(c);
        p_adr.push_back(a);
        m_cursor = (m_cursor + 1) % 256;
        if (a % 4 == 3 || last) flush();
    endfunction

    function automatic void model_reset();
        m_cursor = 0;
        p_chr.delete();
        p_adr.delete();
        exp_q.delete();
    endfunction

    // Monitor: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && ifc.we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual wa=%0d wdata=%0h required none",
                         ifc.wa, ifc.wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_wa", 64'(ifc.wa), 64'(e.wa));
                chk("write_wdata", 64'(ifc.wdata), 64'(e.wd));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic send(logic [7:0] c, bit last);
        int n = 0;
        @(negedge clk);
        ifc.s_valid = 1'b1;
        ifc.s_char  = c;
        ifc.s_last  = last;
        #1;
        while (!ifc.s_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ifc.s_ready) begin
            chk("ready_timeout", 64'(ifc.s_ready), 64'(1));
        end else begin
            model_char(c, last);
            @(posedge clk);
        end
        #1;
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
    endtask

    task automatic do_set_cursor(logic [AW-1:0] v);
        wait_idle();
        set_cursor = 1'b1;
        cursor_in  = v;
        if (p_chr.size() != 0) flush();
        m_cursor = v;
        @(posedge clk);
        #1;
        set_cursor = 1'b0;
    endtask

    task automatic do_clear();
        int n = 0;
        wr_t w;
        wait_idle();
        clear = 1'b1;
        p_chr.delete();
        p_adr.delete();
        for (int i = 0; i < 64; i++) begin
            w.wa = 6'(i);
            w.wd = 32'h0;
            exp_q.push_back(w);
        end
        m_cursor = 0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("clear_busy_cycles", 64'(n), 64'(64));
        chk("clear_ready_after", 64'(ifc.s_ready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r;
        int  n;
        bit  hit;
        ifc.s_valid = 1'b0;
        ifc.s_char  = 8'h00;
        ifc.s_last  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_we", 64'(ifc.we), 64'(0));
        chk("reset_wa", 64'(ifc.wa), 64'(0));
        chk("reset_wdata", 64'(ifc.wdata), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_ready", 64'(ifc.s_ready), 64'(1));
        rst_n = 1'b1;

        send(8'h41, 0);
        send(8'h42, 0);
        send(8'h43, 0);
        send(8'h44, 0);
        @(negedge clk);
        chk("abcd_we", 64'(ifc.we), 64'(1));
        chk("abcd_wa", 64'(ifc.wa), 64'(0));
        chk("abcd_wdata", 64'(ifc.wdata), 64'h44434241);
        chk("abcd_ready_low", 64'(ifc.s_ready), 64'(0));
        @(negedge clk);
        chk("abcd_ready_back", 64'(ifc.s_ready), 64'(1));

        do_set_cursor(8'd5);
        send(8'h58, 0);
        send(8'h59, 1);
        send(8'h21, 1);

        do_set_cursor(8'd0);
        send(8'h5A, 0);
        do_set_cursor(8'd8);
        send(8'h51, 1);

        do_set_cursor(8'd255);
        send(8'h41, 1);
        send(8'h42, 1);

        do_clear();
        send(8'h33, 1);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 82) send(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
            else if (r < 97) do_set_cursor(8'($urandom_range(0, 255)));
            else do_clear();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        do_set_cursor(8'd0);
        wait_idle();
        clear = 1'b1;
        model_reset();
        for (int i = 0; i < 64; i++) exp_q.push_back('{wa: 6'(i), wd: 32'h0});
        @(posedge clk);
        #1;
        clear = 1'b0;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            @(negedge clk);
            #1;
            hit = ifc.we && (ifc.wa == 6'd20);
            n++;
        end
        chk("reach_wa20", 64'(hit), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_we_async", 64'(ifc.we), 64'(0));
        chk("rst_busy_async", 64'(busy), 64'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_we", 64'(ifc.we), 64'(0));
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_ready", 64'(ifc.s_ready), 64'(1));
        repeat (80) @(negedge clk);
        send(8'h61, 1);
        repeat (4) @(negedge clk);
        chk("final_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_writer.md
# text_writer

Packs a byte-wide character stream into 32-bit words and drives the write port of the character text RAM (`we`/`wa`/`wdata`). It sits between the game/score logic, which emits character codes with a cursor, and the text RAM, which the renderer reads one character per address. It also provides a full-screen clear sweep. In each word, byte lane `n` holds the character at character address `4*word + n`, with character 0 in bits [7:0].

## Interface
- `TEXT_WIDTH`, 16, characters per row (power of two)
- `TEXT_HEIGHT`, 16, rows (power of two)
- `FILL_CHAR`, 8'h00, code written to unwritten byte lanes and by clear
- Derived: `ADDR_WIDTH = $clog2(TEXT_WIDTH)+$clog2(TEXT_HEIGHT)`, `WORDS = TEXT_WIDTH*TEXT_HEIGHT/4`

Ports:
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `s_valid` in 1: character available
- `s_char` in 8: character code
- `s_last` in 1: qualifies `s_char`; flush the word after this character
- `s_ready` out 1: character accepted when `s_valid && s_ready`
- `set_cursor` in 1: load cursor (sampled only in IDLE)
- `cursor_in` in ADDR_WIDTH: new character address
- `clear` in 1: start clear sweep (sampled only in IDLE)
- `busy` out 1: WRITE or CLEAR in progress
- `we` out 1: text RAM write enable, one cycle per word
- `wa` out ADDR_WIDTH-2: word address
- `wdata` out 32: packed word

## Operation
- States: IDLE, WRITE, CLEAR.
- `s_ready = (state == IDLE) && !clear && !set_cursor`.
- Registers:
  - `cursor` (ADDR_WIDTH): character address.
  - `buf` (32): word being assembled.
  - `pend`: buf holds at least one accepted byte.
- Priority in IDLE is `clear` > `set_cursor` > character.
- Accept (IDLE, handshake):
  - `buf[8*cursor[1:0] +: 8] <= s_char`; `pend <= 1`.
  - `cursor <= cursor + 1`, wrapping from `2^ADDR_WIDTH-1` to 0.
  - If `cursor[1:0]==3` or `s_last`: register `we<=1`, `wa<=cursor[ADDR_WIDTH-1:2]`, and `wdata` = buf including the new byte. Then `buf <= {4{FILL_CHAR}}`, `pend <= 0`, and go to WRITE.
- WRITE: lasts one cycle. `we` stays high this cycle; `s_ready` is 0. Next state is IDLE with `we <= 0`.
- `set_cursor` (IDLE):
  - Always: `cursor <= cursor_in`.
  - If `pend`: issue a write of the partial buf to the old cursor's word, with unfilled lanes = FILL_CHAR, and go to WRITE.
  - Otherwise: stay in IDLE.
- A partial-word write overwrites the other three lanes of that word with FILL_CHAR. This is by design.
- `clear` (IDLE):
  - Discards `pend`/`buf` and enters CLEAR.
  - Writes `{4{FILL_CHAR}}` to `wa` = 0, 1, …, WORDS-1, one word per cycle.
  - After the last word: `cursor <= 0` and return to IDLE.
  - `clear`, `set_cursor` and `s_valid` are ignored during CLEAR.
- `busy = (state != IDLE)`.

## Timing
- Reset values:
  - Outputs: `we=0`, `wa=0`, `wdata=0`, `busy=0`, `s_ready=1` (IDLE, no commands).
  - Internal: `cursor=0`, `buf={4{FILL_CHAR}}`, `pend=0`.
- Latency: `we` is high in the cycle after the accepting edge of a 4th-lane or `s_last` character.
- Throughput: 4 characters per 5 cycles.
- Clear:
  - `we` is high for exactly WORDS consecutive cycles, starting the cycle after `clear` is sampled.
  - `busy` falls, and `s_ready` rises, the cycle after the last word.
- `wa` and `wdata` are stable whenever `we=1`. Their values when `we=0` are don't-care.
- Wrap: a character at address `2^ADDR_WIDTH-1` writes word WORDS-1, and the next character goes to address 0.
- Reset asserted mid-CLEAR or mid-WRITE aborts immediately: `we` drops asynchronously and all registers take their reset values.

## Configuration
- `TEXT_WRITER_VBLANK_EN` defined:
  - Adds input `vblank` (1 bit).
  - Word writes (WRITE and CLEAR) are issued only while `vblank=1`. The FSM holds its state with `we=0` and `busy=1` until then.
  - `s_ready` stays 0 while a write is stalled.
  - Purpose: keeps the text RAM's read port (which outputs 0 during a write) from glitching visible pixels.
- Undefined: no `vblank` port; writes issue immediately as specified above.

## Test plan
- Reset, then stream "ABCD" (8'h41–8'h44), one per cycle when ready → single `we` with `wa=0`, `wdata=32'h44434241`, then `s_ready` is low for exactly 1 cycle.
- `set_cursor`, `cursor_in=5`, then "XY" with `s_last` on Y (8'h59) → `we`, `wa=1`, `wdata=32'h00595800`; cursor = 7.
- Send 'Z' (8'h5A) at cursor 0 without `s_last`, then `set_cursor`, `cursor_in=8` → `we`, `wa=0`, `wdata=32'h0000005A`; next character lands in word 2, lane 0.
- `clear` with 16×16 geometry → 64 consecutive `we` cycles with `wa` = 0…63 and `wdata=0`; `busy` high for 64 cycles; cursor = 0.
- Cursor 255, send 8'h41 with `s_last`, then 8'h42 with `s_last` → writes `wa=63`, `wdata=32'h41000000`, then `wa=0`, `wdata=32'h00000042`.
- Assert `rst_n=0` at `wa=20` during a clear → `we=0`, `busy=0` and `s_ready=1` immediately after release; no further writes.
